// File: rtl/mdu_pkg.sv
// Shared encodings for the MIPS multiply/divide HI/LO controller.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam int DIV_STEPS = 32;

    // Low 64 bits of a 64x64 product equal the exact 32x32 product once the
    // operands are sign- or zero-extended.
    function automatic logic [63:0] mdu_mul64(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// EX-stage <-> MDU bundle: instruction operands in, stall and HI/LO out.
interface mdu_hilo_ctrl_if;

    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid, op_code, src_a, src_b, flush,
        input  stall_o, busy_o, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, flush,
        output stall_o, busy_o, hi_o, lo_o
    );

endinterface

// File: rtl/mdu_hilo_ctrl_div_iter.sv
// Unsigned 32-step restoring divider core; one quotient bit per cycle.
module div_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      quot_q, quot_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      divisor_q;
    logic [32:0]      shifted;
    logic             ge;

    // Shift next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quot_q[31]};
        ge      = shifted >= {1'b0, divisor_q};
        rem_d   = ge ? 32'(shifted - {1'b0, divisor_q}) : shifted[31:0];
        quot_d  = {quot_q[30:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else if (abort_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            quot_q    <= dividend_i;
            rem_q     <= '0;
            divisor_q <= divisor_i;
        end else if (running_q) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + 1'b1;
            if (done_o) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done_o = running_q && (cnt_q == CNT_W'(DIV_STEPS - 1));
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// MIPS MDU controller: owns HI/LO, sequences multiply/divide, stalls the front end.
// Build option MDU_MUL_MULTICYCLE_EN selects the MUL_LAT-stage multiplier.
module mdu_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    mdu_hilo_ctrl_if.slave bus
);
    import mdu_pkg::*;

    if (MUL_LAT < 1) begin : g_lat_check
        $error("MUL_LAT must be at least 1");
    end

    mdu_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q;
    logic [31:0] opa_q, opb_q;
    logic        sgn_q;
    logic        stall;
    logic        start_op;
    logic        start_div;
    logic        op_sgn;
    logic        div_done;
    logic [31:0] quot, rem;
    logic [31:0] div_hi, div_lo;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    assign op_sgn = (bus.op_code == MDU_MULT) || (bus.op_code == MDU_DIV);

    div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_div),
        .abort_i    (bus.flush),
        .dividend_i (mag32(bus.src_a, op_sgn)),
        .divisor_i  (mag32(bus.src_b, op_sgn)),
        .done_o     (div_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    // Divide-by-zero bypasses the core result so the signed case stays raw.
    always_comb begin
        if (opb_q == '0) begin
            div_hi = opa_q;
            div_lo = '1;
        end else begin
            div_lo = (sgn_q && (opa_q[31] ^ opb_q[31])) ? neg32(quot) : quot;
            div_hi = (sgn_q && opa_q[31]) ? neg32(rem) : rem;
        end
    end

`ifdef MDU_MUL_MULTICYCLE_EN
    localparam int MCNT_W = $clog2(MUL_LAT + 1);

    logic [63:0]       prod_q [MUL_LAT];
    logic [MCNT_W-1:0] mul_cnt_q;
    logic              op_div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) prod_q[k] <= '0;
            mul_cnt_q <= '0;
            op_div_q  <= 1'b0;
        end else begin
            prod_q[0] <= mdu_mul64(opa_q, opb_q, sgn_q);
            for (int k = 1; k < MUL_LAT; k++) prod_q[k] <= prod_q[k-1];
            mul_cnt_q <= (state_q == MUL && !bus.flush) ? mul_cnt_q + 1'b1 : '0;
            if (start_op) op_div_q <= start_div;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall     = 1'b0;
        start_op  = 1'b0;
        start_div = 1'b0;
        case (state_q)
            IDLE: if (bus.op_valid) begin
                case (bus.op_code)
                    MDU_MTHI: hi_d = bus.src_a;
                    MDU_MTLO: lo_d = bus.src_a;
                    MDU_DIV, MDU_DIVU: begin
                        state_d   = DIV;
                        stall     = 1'b1;
                        start_op  = 1'b1;
                        start_div = 1'b1;
                    end
                    MDU_MULT, MDU_MULTU: begin
`ifdef MDU_MUL_MULTICYCLE_EN
                        state_d  = MUL;
                        stall    = 1'b1;
                        start_op = 1'b1;
`else
                        {hi_d, lo_d} = mdu_mul64(bus.src_a, bus.src_b, op_sgn);
`endif
                    end
                    default: ;
                endcase
            end
            MUL: begin
`ifdef MDU_MUL_MULTICYCLE_EN
                stall = 1'b1;
                if (mul_cnt_q == MCNT_W'(MUL_LAT - 1)) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DIV: begin
                stall = 1'b1;
                if (div_done) state_d = DONE;
            end
            DONE: begin
`ifdef MDU_MUL_MULTICYCLE_EN
                {hi_d, lo_d} = op_div_q ? {div_hi, div_lo} : prod_q[MUL_LAT-1];
`else
                {hi_d, lo_d} = {div_hi, div_lo};
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush cancels whatever was decided above, including an accept.
        if (bus.flush) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            stall     = 1'b0;
            start_op  = 1'b0;
            start_div = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
            if (start_op) begin
                opa_q <= bus.src_a;
                opb_q <= bus.src_b;
                sgn_q <= op_sgn;
            end
        end
    end

    assign bus.stall_o = stall;
    assign bus.busy_o  = busy_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl with a cycle-level reference model of HI/LO and stall.
module tb_mdu_hilo_ctrl;
    import mdu_pkg::*;

    localparam int MUL_LAT = 2;
`ifdef MDU_MUL_MULTICYCLE_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif
    localparam int MUL_STALL = MULTI ? 1 + MUL_LAT : 0;
    localparam int DIV_STALL = 1 + DIV_STEPS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_hilo_ctrl_if bus ();
    mdu_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] u;
        case (op)
            MDU_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa * sb;
                return q;
            end
            MDU_MULTU: begin
                u = 64'(a) * 64'(b);
                return u;
            end
            MDU_DIV, MDU_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (op == MDU_DIV) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'(a);
                    sb = longint'(b);
                end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return '0;
        endcase
    endfunction

    function automatic bit is_div(input logic [2:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

    function automatic bit is_mul(input logic [2:0] op);
        return op == MDU_MULT || op == MDU_MULTU;
    endfunction

    // Model: m_left = stalled cycles still owed after accept, m_done = write-back cycle next.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    logic [63:0] m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else if (bus.flush) begin
            m_left = 0; m_done = 1'b0;
        end else if (m_done) begin
            m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (bus.op_valid) begin
            m_r = ref_result(bus.op_code, bus.src_a, bus.src_b);
            if (bus.op_code == MDU_MTHI) m_hi = bus.src_a;
            else if (bus.op_code == MDU_MTLO) m_lo = bus.src_a;
            else if (is_div(bus.op_code)) begin
                m_left = DIV_STEPS; {m_rhi, m_rlo} = m_r;
            end else if (is_mul(bus.op_code)) begin
                if (MULTI) begin m_left = MUL_LAT; {m_rhi, m_rlo} = m_r; end
                else {m_hi, m_lo} = m_r;
            end
        end
    end

    initial begin
        logic exp_stall;
        forever begin
            @(negedge clk); #1;
            if (chk_en) begin
                exp_stall = !bus.flush && (m_left > 0 || (m_left == 0 && !m_done && bus.op_valid
                            && (is_div(bus.op_code) || (MULTI && is_mul(bus.op_code)))));
                check("model_stall", 32'(bus.stall_o), 32'(exp_stall));
                check("model_busy", 32'(bus.busy_o), 32'(m_left > 0 || m_done));
                check("model_hi", bus.hi_o, m_hi);
                check("model_lo", bus.lo_o, m_lo);
            end
        end
    end

    task automatic drive_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = op; bus.src_a = a; bus.src_b = b;
        #2;
    endtask

    // Holds the op while stalled; returns in the final (DONE or accept) cycle.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #2;
        end
        check("stall_bound", 32'(n >= 100), 32'd0);
    endtask

    task automatic release_op();
        @(negedge clk);
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        #2;
    endtask

    task automatic run(input string name, input mdu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int estall);
        int n;
        drive_op(op, a, b);
        wait_done(n);
        check({name, "_stall_cycles"}, 32'(n), 32'(estall));
        release_op();
        check({name, "_hi"}, bus.hi_o, ehi);
        check({name, "_lo"}, bus.lo_o, elo);
    endtask

    initial begin
        int n;
        bus.op_valid = 1'b0; bus.op_code = MDU_MTHI; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0;
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #2;
        check("reset_hi", bus.hi_o, 32'h0);
        check("reset_lo", bus.lo_o, 32'h0);
        check("reset_stall", 32'(bus.stall_o), 32'h0);
        check("reset_busy", 32'(bus.busy_o), 32'h0);
        @(negedge clk); rst = 1'b0;

        drive_op(MDU_MTHI, 32'h1234_5678, 32'h0);
        wait_done(n);
        check("mthi_stall_cycles", 32'(n), 32'd0);
        drive_op(MDU_MTLO, 32'hCAFE_0001, 32'h0);
        check("mthi_hi", bus.hi_o, 32'h1234_5678);
        wait_done(n);
        check("mtlo_stall_cycles", 32'(n), 32'd0);
        release_op();
        check("mtlo_lo", bus.lo_o, 32'hCAFE_0001);

        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = MDU_MTHI; bus.src_a = 32'hDEAD_BEEF; bus.flush = 1'b1;
        #2;
        check("flush_mthi_stall", 32'(bus.stall_o), 32'h0);
        release_op();
        check("flush_mthi_hi", bus.hi_o, 32'h1234_5678);

        run("mult_neg", MDU_MULT, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MUL_STALL);
        run("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_STALL);
        run("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_STALL);
        run("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALL);
        run("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALL);
        run("divu_by0", MDU_DIVU, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF, DIV_STALL);
        run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_STALL);

        run("pre_hi", MDU_MTHI, 32'hAAAA_AAAA, 32'h0, 32'hAAAA_AAAA, 32'h8000_0000, 0);
        run("pre_lo", MDU_MTLO, 32'hAAAA_AAAA, 32'h0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
        drive_op(MDU_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #2;
        check("flush_div_stall", 32'(bus.stall_o), 32'h0);
        release_op();
        check("flush_div_busy", 32'(bus.busy_o), 32'h0);
        check("flush_div_hi", bus.hi_o, 32'hAAAA_AAAA);
        check("flush_div_lo", bus.lo_o, 32'hAAAA_AAAA);

        drive_op(MDU_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1; bus.op_valid = 1'b0;
        #2;
        check("rst_div_hi", bus.hi_o, 32'h0);
        check("rst_div_lo", bus.lo_o, 32'h0);
        check("rst_div_stall", 32'(bus.stall_o), 32'h0);
        check("rst_div_busy", 32'(bus.busy_o), 32'h0);
        @(negedge clk); rst = 1'b0;

        drive_op(MDU_DIVU, 32'd100, 32'd7);
        wait_done(n);
        check("chain_div_stall_cycles", 32'(n), 32'(DIV_STALL));
        drive_op(MDU_MULT, 32'd5, 32'hFFFF_FFFD);
        check("chain_div_hi", bus.hi_o, 32'd2);
        check("chain_div_lo", bus.lo_o, 32'd14);
        wait_done(n);
        check("chain_mul_stall_cycles", 32'(n), 32'(MUL_STALL));
        release_op();
        check("chain_mul_hi", bus.hi_o, 32'hFFFF_FFFF);
        check("chain_mul_lo", bus.lo_o, 32'hFFFF_FFF1);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
